// File: rtl/unified_mem_arbiter_if.sv
// Bundle between the unified memory arbiter, its two requesters (IF and MEM stage)
// and the single-ported memory. The arbiter takes the slave view.
interface unified_mem_arbiter_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
);
   // Handshake: a requester holds req and payload stable until it sees its gnt;
   // gnt is combinational in the request cycle and lasts one cycle per access.
   // Read data comes back with rvalid exactly one cycle after the gnt.
   logic              if_req;
   logic [ADDR_W-1:0] if_addr;
   logic              d_rd;
   logic              d_wr;
   logic [ADDR_W-1:0] d_addr;
   logic [DATA_W-1:0] d_wdata;
   logic [1:0]        d_size;
   logic [DATA_W-1:0] m_rdata;
   logic              if_gnt;
   logic              d_gnt;
   logic              if_rvalid;
   logic [DATA_W-1:0] if_rdata;
   logic              d_rvalid;
   logic [DATA_W-1:0] d_rdata;
   logic [ADDR_W-1:0] m_addr;
   logic [DATA_W-1:0] m_wdata;
   logic [1:0]        m_size;
   logic              m_re;
   logic              m_we;
   logic              if_stall;
   logic [15:0]       conflict_cnt;

   modport slave (
      input  if_req, if_addr, d_rd, d_wr, d_addr, d_wdata, d_size, m_rdata,
      output if_gnt, d_gnt, if_rvalid, if_rdata, d_rvalid, d_rdata,
             m_addr, m_wdata, m_size, m_re, m_we, if_stall, conflict_cnt
   );

   modport master (
      output if_req, if_addr, d_rd, d_wr, d_addr, d_wdata, d_size, m_rdata,
      input  if_gnt, d_gnt, if_rvalid, if_rdata, d_rvalid, d_rdata,
             m_addr, m_wdata, m_size, m_re, m_we, if_stall, conflict_cnt
   );
endinterface

// File: rtl/unified_mem_arbiter.sv
// Arbitrates the single memory port between instruction fetch and load/store,
// steers the one-cycle-late read data to its owner and counts access conflicts.
module unified_mem_arbiter #(
   parameter int ADDR_W   = 32,
   parameter int DATA_W   = 32,
   parameter int MAX_WAIT = 2
) (
   input  logic       clk,
   input  logic       rst,
   unified_mem_arbiter_if.slave bus,
   output logic [1:0] rsp_state_o
);
   typedef enum logic [1:0] {RSP_NONE = 2'd0, RSP_IF = 2'd1, RSP_D = 2'd2} rsp_e;

   localparam logic [3:0] MAX_WAIT_L = 4'(MAX_WAIT);

   rsp_e        rsp_q, rsp_d;
   logic [3:0]  wait_q, wait_d;
   logic [15:0] cnt_q, cnt_d;

   logic              d_req, fetch_pri, if_gnt, d_gnt;
   logic [ADDR_W-1:0] m_addr;
   logic [DATA_W-1:0] m_wdata;
   logic [1:0]        m_size;
   logic              m_re, m_we;

   assign d_req     = bus.d_rd | bus.d_wr;
   assign fetch_pri = (wait_q >= MAX_WAIT_L);
   // Data normally wins a conflict; a fetch starved MAX_WAIT times takes the port.
   assign if_gnt    = ~rst & bus.if_req & (~d_req | fetch_pri);
   assign d_gnt     = ~rst & d_req & ~if_gnt;

   always_comb begin
      m_addr  = '0;
      m_wdata = '0;
      m_size  = 2'b00;
      m_re    = 1'b0;
      m_we    = 1'b0;
      if (if_gnt) begin
         m_addr = bus.if_addr;
         m_size = 2'b10;
         m_re   = 1'b1;
      end else if (d_gnt) begin
         m_addr  = bus.d_addr;
         m_wdata = bus.d_wdata;
         m_size  = bus.d_size;
         m_we    = bus.d_wr;
         m_re    = bus.d_rd & ~bus.d_wr;
      end
   end

   always_comb begin
      rsp_d = RSP_NONE;
      if (if_gnt)                              rsp_d = RSP_IF;
      else if (d_gnt & bus.d_rd & ~bus.d_wr)   rsp_d = RSP_D;
   end

   always_comb begin
      wait_d = wait_q;
      if (~bus.if_req | if_gnt)  wait_d = 4'd0;
      else if (wait_q != 4'hF)   wait_d = wait_q + 4'd1;
      cnt_d = cnt_q;
      if (bus.if_req & d_req & (cnt_q != 16'hFFFF)) cnt_d = cnt_q + 16'd1;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rsp_q  <= RSP_NONE;
         wait_q <= 4'd0;
         cnt_q  <= 16'd0;
      end else begin
         rsp_q  <= rsp_d;
         wait_q <= wait_d;
         cnt_q  <= cnt_d;
      end
   end

   // rst gates the responses too, so a read granted just before reset never surfaces.
   assign bus.if_rvalid    = ~rst & (rsp_q == RSP_IF);
   assign bus.d_rvalid     = ~rst & (rsp_q == RSP_D);
   assign bus.if_rdata     = bus.if_rvalid ? bus.m_rdata : '0;
   assign bus.d_rdata      = bus.d_rvalid  ? bus.m_rdata : '0;
   assign bus.if_gnt       = if_gnt;
   assign bus.d_gnt        = d_gnt;
   assign bus.if_stall     = ~rst & bus.if_req & ~if_gnt;
   assign bus.m_addr       = m_addr;
   assign bus.m_wdata      = m_wdata;
   assign bus.m_size       = m_size;
   assign bus.m_re         = m_re;
   assign bus.m_we         = m_we;
   assign bus.conflict_cnt = cnt_q;
   assign rsp_state_o      = rsp_q;
endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Directed bench for unified_mem_arbiter with a small synchronous memory model.
module tb_unified_mem_arbiter;
  logic        clk;
  logic        rst;
  logic [1:0]  rsp_state;
  int          n_vec;
  int          n_err;
  logic [31:0] mem [0:255];
  logic [31:0] m_rdata_q;
  logic        exp_if [6];

  unified_mem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  unified_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_WAIT(2)) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus.slave),
    .rsp_state_o (rsp_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // memory: writes land on the grant edge, reads return one cycle later
  always @(posedge clk) begin
    if (bus.m_we) mem[bus.m_addr[9:2]] = bus.m_wdata;
    if (bus.m_re) m_rdata_q <= mem[bus.m_addr[9:2]];
  end
  assign bus.m_rdata = m_rdata_q;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic apply(input logic r, input logic ir, input logic [31:0] ia,
                       input logic dr, input logic dw, input logic [31:0] da,
                       input logic [31:0] wd, input logic [1:0] ds);
    @(negedge clk);
    rst = r; bus.if_req = ir; bus.if_addr = ia;
    bus.d_rd = dr; bus.d_wr = dw; bus.d_addr = da; bus.d_wdata = wd; bus.d_size = ds;
    #1;
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    m_rdata_q = '0;
    for (int i = 0; i < 256; i++) mem[i] = 32'h0;
    mem[1]    = 32'h0040_0093;
    mem[8'h20] = 32'h1111_2222;
    exp_if = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    rst = 1'b1; bus.if_req = 1'b1; bus.if_addr = 32'h4;
    bus.d_rd = 1'b1; bus.d_wr = 1'b0; bus.d_addr = 32'h80;
    bus.d_wdata = '0; bus.d_size = 2'b10;

    // reset with both requesters active
    for (int c = 0; c < 2; c++) begin
      apply(1, 1, 32'h4, 1, 0, 32'h80, 0, 2'b10);
      check("rst_if_gnt", {31'b0, bus.if_gnt}, 0);
      check("rst_d_gnt", {31'b0, bus.d_gnt}, 0);
      check("rst_rvalid", {30'b0, bus.if_rvalid, bus.d_rvalid}, 0);
      check("rst_re_we", {30'b0, bus.m_re, bus.m_we}, 0);
      check("rst_stall", {31'b0, bus.if_stall}, 0);
      check("rst_m_addr", bus.m_addr, 0);
    end
    check("rst_conflict", {16'b0, bus.conflict_cnt}, 0);

    // contention: D, D, IF, D, D, IF
    for (int k = 0; k < 6; k++) begin
      apply(0, 1, 32'h4, 1, 0, 32'h80, 0, 2'b10);
      check("arb_if_gnt", {31'b0, bus.if_gnt}, {31'b0, exp_if[k]});
      check("arb_d_gnt", {31'b0, bus.d_gnt}, {31'b0, ~exp_if[k]});
      check("arb_stall", {31'b0, bus.if_stall}, {31'b0, ~exp_if[k]});
      check("arb_m_addr", bus.m_addr, exp_if[k] ? 32'h4 : 32'h80);
      check("arb_conflict", {16'b0, bus.conflict_cnt}, k);
      check("arb_if_rvalid", {31'b0, bus.if_rvalid}, (k > 0 && exp_if[k-1]) ? 1 : 0);
      check("arb_d_rvalid", {31'b0, bus.d_rvalid}, (k > 0 && !exp_if[k-1]) ? 1 : 0);
      if (k > 0) check("arb_rdata", exp_if[k-1] ? bus.if_rdata : bus.d_rdata,
                       exp_if[k-1] ? 32'h0040_0093 : 32'h1111_2222);
    end
    apply(0, 0, 0, 0, 0, 0, 0, 0);
    check("idle_if_rvalid", {31'b0, bus.if_rvalid}, 1);
    check("idle_m_addr", bus.m_addr, 0);
    check("idle_m_size", {30'b0, bus.m_size}, 0);

    // fetch only
    apply(0, 1, 32'h4, 0, 0, 0, 0, 0);
    check("f_if_gnt", {31'b0, bus.if_gnt}, 1);
    check("f_m_re", {31'b0, bus.m_re}, 1);
    check("f_m_size", {30'b0, bus.m_size}, 2);
    check("f_stall", {31'b0, bus.if_stall}, 0);
    apply(0, 0, 0, 0, 0, 0, 0, 0);
    check("f_if_rvalid", {31'b0, bus.if_rvalid}, 1);
    check("f_if_rdata", bus.if_rdata, 32'h0040_0093);
    check("f_d_rdata", bus.d_rdata, 0);

    // store then load to the same address
    apply(0, 0, 0, 0, 1, 32'h100, 32'hDEAD_BEEF, 2'b10);
    check("st_d_gnt", {31'b0, bus.d_gnt}, 1);
    check("st_m_we_re", {30'b0, bus.m_we, bus.m_re}, 2);
    check("st_m_wdata", bus.m_wdata, 32'hDEAD_BEEF);
    apply(0, 0, 0, 1, 0, 32'h100, 0, 2'b10);
    check("ld_m_we_re", {30'b0, bus.m_we, bus.m_re}, 1);
    check("st_no_rvalid", {31'b0, bus.d_rvalid}, 0);
    apply(0, 0, 0, 0, 0, 0, 0, 0);
    check("ld_d_rvalid", {31'b0, bus.d_rvalid}, 1);
    check("ld_d_rdata", bus.d_rdata, 32'hDEAD_BEEF);

    // rd and wr together behave as a store
    apply(0, 0, 0, 1, 1, 32'h104, 32'h1234_5678, 2'b10);
    check("rw_m_we_re", {30'b0, bus.m_we, bus.m_re}, 2);
    apply(0, 0, 0, 1, 0, 32'h104, 0, 2'b10);
    check("rw_no_rvalid", {31'b0, bus.d_rvalid}, 0);
    apply(0, 0, 0, 0, 0, 0, 0, 0);
    check("rw_rdata", bus.d_rdata, 32'h1234_5678);

    // reset right after a fetch grant drops the response
    apply(0, 1, 32'h4, 0, 0, 0, 0, 0);
    check("rr_if_gnt", {31'b0, bus.if_gnt}, 1);
    apply(1, 0, 0, 0, 0, 0, 0, 0);
    check("rr_rvalid_n1", {31'b0, bus.if_rvalid}, 0);
    check("rr_rdata_n1", bus.if_rdata, 0);
    apply(0, 0, 0, 0, 0, 0, 0, 0);
    check("rr_rvalid_n2", {31'b0, bus.if_rvalid}, 0);
    check("rr_state", {30'b0, rsp_state}, 0);

    // conflict counter saturation
    for (int k = 0; k < 65540; k++) begin
      apply(0, 1, 32'h4, 1, 0, 32'h80, 0, 2'b10);
      if (k == 65534) check("sat_below", {16'b0, bus.conflict_cnt}, 32'hFFFE);
    end
    apply(0, 1, 32'h4, 1, 0, 32'h80, 0, 2'b10);
    check("sat_hold", {16'b0, bus.conflict_cnt}, 32'hFFFF);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/unified_mem_arbiter.md
Name: unified_mem_arbiter

Overview:
- Shares the single-ported unified instruction/data memory of the pipelined RISC-V datapath between two requesters: the IF stage (instruction fetch) and the MEM stage (load/store).
- Grants the port once per cycle and routes synchronous read data back to the owner one cycle later.
- Generates the fetch-stall signal for the PC/IF-ID registers.
- Keeps a saturating conflict counter that the datapath can select onto the LED/SSD display.

Parameters:
- ADDR_W, 32, byte address width
- DATA_W, 32, data width
- MAX_WAIT, 2, consecutive fetch denials after which fetch overrides data priority (range 1..15)

Ports:
- clk  input  1  system clock, all state on the rising edge
- rst  input  1  synchronous, active-high reset
- if_req  input  1  fetch request
- if_addr  input  ADDR_W  fetch address
- d_rd  input  1  load request
- d_wr  input  1  store request
- d_addr  input  ADDR_W  load/store address
- d_wdata  input  DATA_W  store data
- d_size  input  2  00 byte, 01 half, 10 word
- m_rdata  input  DATA_W  memory read data, valid the cycle after m_re
- if_gnt  output  1  fetch granted this cycle
- d_gnt  output  1  data access granted this cycle
- if_rvalid  output  1  if_rdata valid
- if_rdata  output  DATA_W  fetched instruction
- d_rvalid  output  1  d_rdata valid
- d_rdata  output  DATA_W  load data
- m_addr  output  ADDR_W  memory address
- m_wdata  output  DATA_W  memory write data
- m_size  output  2  memory access size
- m_re  output  1  memory read enable
- m_we  output  1  memory write enable
- if_stall  output  1  if_req & ~if_gnt
- conflict_cnt  output  16  count of cycles in which both requesters were active

Behaviour:
- Requester handshake:
  - A requester holds its request and payload stable until it sees its gnt.
  - The gnt is combinational in the same cycle as the request; each gnt lasts exactly one cycle per access.
- Data request: d_req = d_rd | d_wr. If d_rd and d_wr are both high, the access is a store: m_we=1, m_re=0, and no d_rvalid follows.
- Arbitration, one grant per cycle:
  - Only one requester active: that requester is granted.
  - Both active: data wins, unless wait_cnt >= MAX_WAIT, in which case fetch wins.
- wait_cnt (4-bit register):
  - Increments when if_req=1 and if_gnt=0.
  - Clears to 0 on an if_gnt or when if_req=0.
  - Saturates at 15.
- Memory port:
  - Driven combinationally from the granted requester.
  - Fetch grant: m_re=1, m_size=10.
  - No grant: m_re=m_we=0; m_addr, m_wdata and m_size = 0.
- Response FSM (registered owner of the outstanding read); states RSP_NONE, RSP_IF, RSP_D:
  - Next state RSP_IF if if_gnt this cycle.
  - Next state RSP_D if d_gnt & d_rd & ~d_wr.
  - Otherwise RSP_NONE.
  - In RSP_IF: if_rvalid=1, if_rdata=m_rdata.
  - In RSP_D: d_rvalid=1, d_rdata=m_rdata.
  - The non-owner's rvalid is 0 and its rdata is 0.
- Read latency: exactly 1 cycle from gnt to rvalid. Back-to-back grants pipeline, so a new grant can coincide with the previous response.
- Writes take effect at the memory on the grant cycle edge. Store then load to the same address in consecutive cycles returns the stored data; the memory guarantees this, and the arbiter adds no forwarding.
- conflict_cnt:
  - Increments on every cycle with if_req & d_req.
  - Saturates at 16'hFFFF; no wrap.
- Reset:
  - While rst=1, all gnt/re/we/rvalid outputs are forced to 0 regardless of requests.
  - FSM goes to RSP_NONE; wait_cnt=0; conflict_cnt=0; all data outputs are 0.
  - Reset asserted mid-access discards the pending response: no rvalid in the cycle after rst deasserts.
- if_stall is forced to 0 during rst.

Test Plan:
- rst=1 for 2 cycles with if_req=d_rd=1 -> all gnt, rvalid, m_re and m_we are 0; conflict_cnt=0. After release, first cycle: d_gnt=1.
- if_req only, if_addr=0x0000_0004, memory word 0x0040_0093 -> if_gnt=1 and m_re=1 in cycle N; if_rvalid=1 with if_rdata=0x0040_0093 in N+1; if_stall=0.
- if_req and d_rd held every cycle with MAX_WAIT=2 -> grant sequence D, D, IF, D, D, IF ...; if_stall=1 on the D cycles; conflict_cnt increments every cycle.
- d_wr=1, d_addr=0x100, d_wdata=0xDEADBEEF, d_size=10, then d_rd to 0x100 in the next cycle -> m_we=1 then m_re=1; d_rvalid=1 with d_rdata=0xDEADBEEF one cycle later; no d_rvalid after the store.
- d_rd and d_wr both high -> treated as a store: m_we=1, m_re=0, d_rvalid=0 in the next cycle.
- Grant fetch in cycle N, rst=1 in N+1 -> if_rvalid=0 in N+1 and N+2. Preload conflict_cnt near saturation via 65540 conflict cycles -> value stays at 0xFFFF.
